// File: rtl/des_key_if.sv
// Handshake bundle between the DES key schedule and its consumer.
// The master side loads keys and accepts subkeys; the slave side is the schedule.
interface des_key_if;
  logic        key_load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  modport master (
    output key_load, key_in, decrypt, subkey_ready,
    input  subkey_valid, subkey, round_idx, busy, done
  );

  modport slave (
    input  key_load, key_in, decrypt, subkey_ready,
    output subkey_valid, subkey, round_idx, busy, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: PC-1 on load, then one PC-2 subkey per accepted
// handshake, walking C/D forward (encrypt) or backward (decrypt).
module des_key_schedule (
  input  logic     clk,
  input  logic     rst,
  des_key_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  // Table entries are DES bit numbers, bit 1 being the MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      state_q, state_nxt;
  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  idx_q, idx_nxt;
  logic        mode_q, mode_nxt;
  logic        done_q, done_nxt;
  logic        two;
  logic [55:0] cd0, cd;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd0[55-i] = bus.key_in[64-PC1[i]];
  end

  // Subkey comes only from the C/D registers so it never glitches with inputs.
  assign cd = {c_q, d_q};
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign bus.subkey[47-i] = cd[56-PC2[i]];
  end

  logic unused_parity;
  assign unused_parity = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                           bus.key_in[24], bus.key_in[16], bus.key_in[8],  bus.key_in[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
      idx_q   <= idx_nxt;
      mode_q  <= mode_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    c_nxt     = c_q;
    d_nxt     = d_q;
    idx_nxt   = idx_q;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    // Single shifts sit between rounds 1-2, 8-9 and 15-16 in either direction.
    two       = !((idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14));
    case (state_q)
      IDLE: begin
        if (bus.key_load) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          mode_nxt  = bus.decrypt;
          // K16 sits at total rotation 28, i.e. the unrotated PC-1 halves.
          if (bus.decrypt) begin
            c_nxt = cd0[55:28];
            d_nxt = cd0[27:0];
          end else begin
            c_nxt = rotl(cd0[55:28], 1'b0);
            d_nxt = rotl(cd0[27:0], 1'b0);
          end
        end
      end
      RUN: begin
        if (bus.subkey_ready) begin
          if (idx_q == 4'd15) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx_q + 4'd1;
            if (mode_q) begin
              c_nxt = rotr(c_q, two);
              d_nxt = rotr(d_q, two);
            end else begin
              c_nxt = rotl(c_q, two);
              d_nxt = rotl(d_q, two);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.subkey_valid = (state_q == RUN);
  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.round_idx    = idx_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a direct (total-rotation) DES key model
// queues expected subkeys at load time; a negedge monitor pops them on each accept.
module tb_des_key_schedule;
  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEYP  = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY2  = 64'h0123456789ABCDEF;
  localparam logic [47:0] K1    = 48'h1B02EFFC7072;
  localparam logic [47:0] K2    = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  logic clk, rst;
  des_key_if bus();

  des_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q[$];
  int          total, bad, acc_cnt, done_cnt, exp_done;
  logic        hold_vld, prev_done;
  logic [47:0] hold_sk;
  logic [3:0]  hold_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Subkey for DES round rnd (1..16) straight from PC-1, cumulative shift, PC-2.
  function automatic logic [47:0] m_subkey(input logic [63:0] k, input int rnd);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    int s;
    s = 0;
    for (int r = 0; r < rnd; r++) s += SHIFTS[r];
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], 1'(k >> (64 - PC1[i]))};
    c = cd[55:28];
    d = cd[27:0];
    c = (c << s) | (c >> (28 - s));
    d = (d << s) | (d >> (28 - s));
    cd = {c, d};
    sk = '0;
    for (int i = 0; i < 48; i++) sk = {sk[46:0], 1'(cd >> (56 - PC2[i]))};
    return sk;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_vld  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_sk",  64'(bus.subkey),       64'(hold_sk));
        chk("hold_idx", 64'(bus.round_idx),    64'(hold_idx));
        chk("hold_vld", 64'(bus.subkey_valid), 64'd1);
      end
      if (bus.subkey_valid && bus.subkey_ready) begin
        if (q.size() == 0) chk("sb_underflow", 64'(q.size()), 64'd1);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("subkey", 64'(bus.subkey),    64'(e.sk));
          chk("idx",    64'(bus.round_idx), 64'(e.idx));
          acc_cnt++;
        end
      end
      if (bus.done) begin
        chk("done_after16", 64'(acc_cnt), 64'd16);
        chk("done_busy",    64'(bus.busy), 64'd0);
        chk("done_pulse",   64'({prev_done, bus.done}), 64'b01);
        acc_cnt = 0;
        done_cnt++;
      end
      hold_vld  = bus.subkey_valid && !bus.subkey_ready;
      hold_sk   = bus.subkey;
      hold_idx  = bus.round_idx;
      prev_done = bus.done;
    end
  end

  // Called at posedge+1 with the DUT idle; leaves us in the first RUN cycle.
  task automatic load(input logic [63:0] k, input logic dec);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    bus.decrypt  = dec;
    for (int n = 0; n < 16; n++) q.push_back('{m_subkey(k, dec ? 16 - n : n + 1), 4'(n)});
    exp_done++;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    bus.key_in   = {$urandom, $urandom};
    bus.decrypt  = 1'($urandom);
    chk("load_vld",  64'(bus.subkey_valid), 64'd1);
    chk("load_busy", 64'(bus.busy),         64'd1);
    chk("load_idx",  64'(bus.round_idx),    64'd0);
  endtask

  task automatic run_to_done(input int pat);
    int cyc;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      bus.subkey_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
    bus.subkey_ready = 1'b1;
  endtask

  task automatic wait_idx(input logic [3:0] v);
    int n;
    n = 0;
    while (bus.round_idx !== v && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idx", 64'(bus.round_idx), 64'(v));
  endtask

  initial begin
    total = 0; bad = 0; acc_cnt = 0; done_cnt = 0; exp_done = 0;
    hold_vld = 1'b0; prev_done = 1'b0;
    rst = 1'b1;
    bus.key_load = 1'b0; bus.key_in = '0; bus.decrypt = 1'b0; bus.subkey_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  64'(bus.subkey_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy),         64'd0);
    chk("rst_done", 64'(bus.done),         64'd0);
    chk("rst_sk",   64'(bus.subkey),       64'd0);
    chk("rst_idx",  64'(bus.round_idx),    64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Encrypt order with anchors from the classic worked example.
    load(KEY, 1'b0);
    chk("enc_k1", 64'(bus.subkey), 64'(K1));
    @(posedge clk); #1;
    chk("enc_k2",  64'(bus.subkey),    64'(K2));
    chk("enc_i1",  64'(bus.round_idx), 64'd1);
    run_to_done(0);

    // Decrypt order.
    load(KEY, 1'b1);
    chk("dec_k16", 64'(bus.subkey), 64'(K16));
    run_to_done(0);

    // Backpressure.
    bus.subkey_ready = 1'b0;
    load(KEY, 1'b0);
    run_to_done(1);
    @(posedge clk); #1;
    chk("bp_idle", 64'(bus.busy), 64'd0);

    // Load during RUN is ignored; load in the done cycle starts a new schedule.
    load(KEY, 1'b0);
    wait_idx(4'd3);
    bus.key_load = 1'b1; bus.key_in = 64'h0;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    chk("ign_idx",  64'(bus.round_idx), 64'd4);
    chk("ign_busy", 64'(bus.busy),      64'd1);
    run_to_done(0);
    load(KEY2, 1'b0);
    run_to_done(0);

    // Reset mid-run.
    load(KEY, 1'b0);
    wait_idx(4'd5);
    rst = 1'b1;
    #1;
    chk("mrst_vld",  64'(bus.subkey_valid), 64'd0);
    chk("mrst_busy", 64'(bus.busy),         64'd0);
    chk("mrst_done", 64'(bus.done),         64'd0);
    chk("mrst_sk",   64'(bus.subkey),       64'd0);
    q.delete();
    acc_cnt = 0;
    exp_done--;
    @(posedge clk); #1;
    chk("mrst_nodone", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_nodone2", 64'(bus.done), 64'd0);
    load(KEY, 1'b0);
    chk("mrst_k1", 64'(bus.subkey), 64'(K1));
    run_to_done(0);

    // Parity bits ignored; all-zero key.
    load(KEYP, 1'b0);
    chk("par_k1", 64'(bus.subkey), 64'(K1));
    run_to_done(0);
    load(64'h0, 1'b0);
    chk("zero_k1", 64'(bus.subkey), 64'd0);
    run_to_done(0);

    @(posedge clk); #1;
    chk("done_total", 64'(done_cnt), 64'(exp_done));
    chk("sb_empty",   64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
